// File: rtl/alu_seq_pkg.sv
// Shared encodings for the ALU command sequencer: FSM states, op codes,
// input-mux one-hot selects and the output-select bit map.
package alu_seq_pkg;

    typedef enum logic [2:0] {
        S_OFF,
        S_READY,
        S_LOAD,
        S_EXEC,
        S_RESP,
        S_ERROR
    } state_t;

    localparam logic [2:0] OP_AND = 3'd0;
    localparam logic [2:0] OP_OR  = 3'd1;
    localparam logic [2:0] OP_NOT = 3'd2;
    localparam logic [2:0] OP_XOR = 3'd3;
    localparam logic [2:0] OP_ADD = 3'd4;
    localparam logic [2:0] OP_SUB = 3'd5;
    localparam logic [2:0] OP_MUL = 3'd6;

    // {persist, load, reset}
    localparam logic [2:0] IN_SEL_RESET   = 3'b001;
    localparam logic [2:0] IN_SEL_LOAD    = 3'b010;
    localparam logic [2:0] IN_SEL_PERSIST = 3'b100;

    // Output-select bit positions; note NOT and XOR are swapped relative to op codes
    localparam int OUT_SEL_W = 7;
    localparam int OUT_AND   = 0;
    localparam int OUT_OR    = 1;
    localparam int OUT_XOR   = 2;
    localparam int OUT_NOT   = 3;
    localparam int OUT_ADD   = 4;
    localparam int OUT_SUB   = 5;
    localparam int OUT_MUL   = 6;

endpackage

// File: rtl/alu_seq_op_decode.sv
// Combinational decode of a 3-bit command op into the ALU one-hot output
// select, plus a legal flag (op 7 is the only illegal code).
module alu_seq_op_decode
    import alu_seq_pkg::*;
(
    input  logic [2:0]           op,
    output logic [OUT_SEL_W-1:0] out_sel,
    output logic                 legal
);

    always_comb begin
        out_sel = '0;
        legal   = 1'b1;
        case (op)
            OP_AND:  out_sel[OUT_AND] = 1'b1;
            OP_OR:   out_sel[OUT_OR]  = 1'b1;
            OP_NOT:  out_sel[OUT_NOT] = 1'b1;
            OP_XOR:  out_sel[OUT_XOR] = 1'b1;
            OP_ADD:  out_sel[OUT_ADD] = 1'b1;
            OP_SUB:  out_sel[OUT_SUB] = 1'b1;
            OP_MUL:  out_sel[OUT_MUL] = 1'b1;
            default: legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_sequencer.sv
// Command/response sequencer for the accumulator ALU with result chaining.
// Define ALU_SEQ_STICKY_ERR_EN to add err_clr and make the ERROR state sticky.
module alu_sequencer
    import alu_seq_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int EXEC_CYCLES = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [2:0]           cmd_op,
    input  logic                 cmd_chain,
    input  logic [WIDTH-1:0]     cmd_a,
    input  logic [WIDTH-1:0]     cmd_b,
    output logic [2:0]           alu_in_sel,
    output logic [WIDTH-1:0]     alu_num1,
    output logic [WIDTH-1:0]     alu_num2,
    output logic [OUT_SEL_W-1:0] alu_out_sel,
    input  logic [WIDTH-1:0]     alu_result,
    input  logic                 alu_overflow,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [WIDTH-1:0]     rsp_data,
    output logic                 rsp_err,
    output logic                 busy
`ifdef ALU_SEQ_STICKY_ERR_EN
    ,
    input  logic                 err_clr
`endif
);

    localparam int CNT_W = (EXEC_CYCLES > 1) ? $clog2(EXEC_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(EXEC_CYCLES - 1);

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0]       num1_q, num1_d;
    logic [WIDTH-1:0]       num2_q, num2_d;
    logic [OUT_SEL_W-1:0]   out_sel_q, out_sel_d;
    logic [WIDTH-1:0]       rsp_data_q, rsp_data_d;
    logic                   rsp_err_q, rsp_err_d;
    logic [WIDTH-1:0]       last_q, last_d;
    logic [OUT_SEL_W-1:0]   dec_out_sel;
    logic                   dec_legal;
    logic                   err_exit;

    alu_seq_op_decode u_dec (
        .op      (cmd_op),
        .out_sel (dec_out_sel),
        .legal   (dec_legal)
    );

`ifdef ALU_SEQ_STICKY_ERR_EN
    assign err_exit = err_clr;
`else
    assign err_exit = 1'b1;
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        num1_d     = num1_q;
        num2_d     = num2_q;
        out_sel_d  = out_sel_q;
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;
        last_d     = last_q;
        alu_in_sel = IN_SEL_RESET;
        cmd_ready  = 1'b0;
        case (state_q)
            S_OFF: begin
                if (en) state_d = S_READY;
            end
            S_READY: begin
                alu_in_sel = IN_SEL_LOAD;
                if (!en) begin
                    state_d = S_OFF;
                end else begin
                    cmd_ready = 1'b1;
                    if (cmd_valid) begin
                        if (dec_legal) begin
                            state_d   = S_LOAD;
                            num1_d    = cmd_chain ? last_q : cmd_a;
                            num2_d    = cmd_b;
                            out_sel_d = dec_out_sel;
                        end else begin
                            // Illegal op answers straight away without touching the ALU
                            state_d    = S_RESP;
                            rsp_data_d = '0;
                            rsp_err_d  = 1'b1;
                        end
                    end
                end
            end
            S_LOAD: begin
                alu_in_sel = IN_SEL_LOAD;
                cnt_d      = '0;
                state_d    = S_EXEC;
            end
            S_EXEC: begin
                alu_in_sel = IN_SEL_PERSIST;
                if (cnt_q == CNT_LAST) begin
                    rsp_data_d = alu_result;
                    rsp_err_d  = alu_overflow;
                    last_d     = alu_result;
                    state_d    = S_RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_RESP: begin
                alu_in_sel = IN_SEL_PERSIST;
                if (rsp_ready) begin
                    if (rsp_err_q) state_d = S_ERROR;
                    else           state_d = en ? S_READY : S_OFF;
                end
            end
            S_ERROR: begin
                last_d = '0;
                if (err_exit) state_d = en ? S_READY : S_OFF;
            end
            default: state_d = S_OFF;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_OFF;
            cnt_q      <= '0;
            num1_q     <= '0;
            num2_q     <= '0;
            out_sel_q  <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
            last_q     <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            num1_q     <= num1_d;
            num2_q     <= num2_d;
            out_sel_q  <= out_sel_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
            last_q     <= last_d;
        end
    end

    assign alu_num1    = num1_q;
    assign alu_num2    = num2_q;
    assign alu_out_sel = out_sel_q;
    assign rsp_valid   = (state_q == S_RESP);
    assign rsp_data    = rsp_data_q;
    assign rsp_err     = rsp_err_q;
    assign busy        = (state_q != S_OFF) && (state_q != S_READY);

endmodule
